layer_compositor: RTL and testbench

//  Pipelined, parametrised successor to the combinational graphics top: merges N_LAYERS pixel-driver

---
 rtl/layer_compositor.sv | 154 +++++++++++++++
 tb/tb_layer_compositor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor: priority layer merge / colour-bar test pattern in stage 1,
// per-channel fade scaling in stage 2, with a frame-paced fade FSM around screen changes.
module layer_compositor #(
    parameter int          N_LAYERS  = 6,
    parameter int          SCREEN_W  = 3,
    parameter int          FADE_LOG2 = 3,
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter logic [23:0] BG_COLOR  = 24'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            VGA_row,
    input  logic [9:0]            VGA_col,
    input  logic                  pix_valid,
    input  logic                  frame_start,
    input  logic [N_LAYERS*24-1:0] layer_color,
    input  logic [N_LAYERS-1:0]   layer_active,
    input  logic [N_LAYERS-1:0]   layer_enable,
    input  logic [SCREEN_W-1:0]   req_screen,
    input  logic                  testpattern_active,
    output logic [SCREEN_W-1:0]   shown_screen,
    output logic                  fade_busy,
    output logic [23:0]           output_color,
    output logic                  output_valid
);
    localparam int              LW        = FADE_LOG2 + 1;
    localparam logic [LW-1:0]   LEVEL_MAX = LW'(1 << FADE_LOG2);
    localparam logic [9:0]      BAR_W     = 10'(H_RES / 8);
    localparam logic [9:0]      HALF_ROWS = 10'(V_RES / 2);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FADE_OUT = 2'd1;
    localparam logic [1:0] ST_FADE_IN  = 2'd2;

    logic [1:0]          state_reg, state_next;
    logic [LW-1:0]       level_reg, level_next;
    logic [SCREEN_W-1:0] pending_reg, pending_next;
    logic [SCREEN_W-1:0] shown_reg, shown_next;

    logic [23:0] s1_color_reg, s1_color_next;
    logic        s1_tp_reg;
    logic        s1_valid_reg;
    logic [23:0] out_color_reg, out_color_next;
    logic        out_valid_reg;

    logic [23:0] layer_pick;
    logic [23:0] tp_color;
    logic [9:0]  bar;
    logic [23:0] scaled;

    // Later (higher-index) layers overwrite earlier ones, giving top priority to the highest index.
    always_comb begin
        layer_pick = BG_COLOR;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (layer_active[i] && layer_enable[i]) begin
                layer_pick = layer_color[i*24 +: 24];
            end
        end
    end

    // Bar index bits: R on when bit1 clear (0,1,4,5), G when bit2 clear (0..3), B when bit0 clear.
    always_comb begin
        bar      = VGA_col / BAR_W;
        tp_color = 24'h0;
        if (VGA_row < HALF_ROWS && bar < 10'd8) begin
            tp_color[23:16] = bar[1] ? 8'h00 : 8'hFF;
            tp_color[15:8]  = bar[2] ? 8'h00 : 8'hFF;
            tp_color[7:0]   = bar[0] ? 8'h00 : 8'hFF;
        end
    end

    assign s1_color_next = testpattern_active ? tp_color : layer_pick;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [8+LW-1:0] product;
            assign product = {{LW{1'b0}}, s1_color_reg[gi*8 +: 8]} * {8'b0, level_reg};
            assign scaled[gi*8 +: 8] = 8'(product >> FADE_LOG2);
        end
    endgenerate

    assign out_color_next = s1_tp_reg ? s1_color_reg : scaled;

    always_comb begin
        state_next   = state_reg;
        level_next   = level_reg;
        pending_next = pending_reg;
        shown_next   = shown_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_screen != shown_reg) begin
                    pending_next = req_screen;
                    state_next   = ST_FADE_OUT;
                end
            end
            ST_FADE_OUT: begin
                pending_next = req_screen;
                if (frame_start) begin
                    if (level_reg <= LW'(1)) begin
                        level_next = '0;
                        shown_next = pending_next;
                        state_next = ST_FADE_IN;
                    end else begin
                        level_next = level_reg - LW'(1);
                    end
                end
            end
            ST_FADE_IN: begin
                // A new request reverses direction from wherever the level currently sits.
                if (req_screen != shown_reg) begin
                    pending_next = req_screen;
                    state_next   = ST_FADE_OUT;
                end else if (frame_start) begin
                    level_next = level_reg + LW'(1);
                    if (level_next == LEVEL_MAX) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            level_reg     <= LEVEL_MAX;
            pending_reg   <= '0;
            shown_reg     <= '0;
            s1_color_reg  <= 24'h0;
            s1_tp_reg     <= 1'b0;
            s1_valid_reg  <= 1'b0;
            out_color_reg <= 24'h0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            level_reg     <= level_next;
            pending_reg   <= pending_next;
            shown_reg     <= shown_next;
            s1_color_reg  <= s1_color_next;
            s1_tp_reg     <= testpattern_active;
            s1_valid_reg  <= pix_valid;
            out_color_reg <= out_color_next;
            out_valid_reg <= s1_valid_reg;
        end
    end

    assign shown_screen = shown_reg;
    assign fade_busy    = (state_reg != ST_IDLE);
    assign output_color = out_color_reg;
    assign output_valid = out_valid_reg;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed scenarios plus random traffic, every cycle compared
// against a frame-level behavioural model of compositing and fading.
module tb_layer_compositor;
    localparam int N = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [9:0]      row, col;
    logic            pix_valid, frame_start;
    logic [23:0]     lc [N];
    logic [N*24-1:0] layer_color;
    logic [N-1:0]    act, en;
    logic [2:0]      req;
    logic            tp;
    logic [2:0]      shown_screen;
    logic            fade_busy;
    logic [23:0]     output_color;
    logic            output_valid;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign layer_color[gi*24 +: 24] = lc[gi];
    end

    layer_compositor dut (
        .clk(clk), .rst(rst), .VGA_row(row), .VGA_col(col),
        .pix_valid(pix_valid), .frame_start(frame_start),
        .layer_color(layer_color), .layer_active(act), .layer_enable(en),
        .req_screen(req), .testpattern_active(tp),
        .shown_screen(shown_screen), .fade_busy(fade_busy),
        .output_color(output_color), .output_valid(output_valid)
    );

    int tests = 0;
    int fails = 0;

    typedef enum {M_IDLE, M_OUT, M_IN} phase_t;
    phase_t      m_phase;
    int          m_level;
    logic [2:0]  m_shown;
    logic [23:0] m_s1_color, m_out_color;
    logic        m_s1_tp, m_s1_valid, m_out_valid;

    function automatic logic [23:0] ref_pixel();
        int b;
        if (tp) begin
            if (row >= 240) return 24'h0;
            b = int'(col) / 80;
            return {((b == 0 || b == 1 || b == 4 || b == 5) ? 8'hFF : 8'h00),
                    ((b < 4) ? 8'hFF : 8'h00),
                    ((b % 2 == 0) ? 8'hFF : 8'h00)};
        end
        for (int i = N - 1; i >= 0; i--)
            if (act[i] && en[i]) return lc[i];
        return 24'h0;
    endfunction

    function automatic logic [23:0] fade(logic [23:0] c, int lvl);
        int r, g, b;
        r = int'(c[23:16]) * lvl / 8;
        g = int'(c[15:8]) * lvl / 8;
        b = int'(c[7:0]) * lvl / 8;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_phase = M_IDLE; m_level = 8; m_shown = 3'd0;
            m_s1_color = 24'h0; m_s1_tp = 1'b0; m_s1_valid = 1'b0;
            m_out_color = 24'h0; m_out_valid = 1'b0;
            return;
        end
        m_out_color = m_s1_tp ? m_s1_color : fade(m_s1_color, m_level);
        m_out_valid = m_s1_valid;
        m_s1_color  = ref_pixel();
        m_s1_tp     = tp;
        m_s1_valid  = pix_valid;
        if (m_phase == M_IDLE) begin
            if (req != m_shown) m_phase = M_OUT;
        end else if (m_phase == M_OUT) begin
            if (frame_start) begin
                m_level = (m_level > 0) ? m_level - 1 : 0;
                if (m_level == 0) begin
                    m_shown = req;
                    m_phase = M_IN;
                end
            end
        end else begin
            if (req != m_shown) m_phase = M_OUT;
            else if (frame_start) begin
                m_level = m_level + 1;
                if (m_level == 8) m_phase = M_IDLE;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("color", 32'(output_color), 32'(m_out_color));
        check("valid", 32'(output_valid), 32'(m_out_valid));
        check("shown", 32'(shown_screen), 32'(m_shown));
        check("busy",  32'(fade_busy), 32'(m_phase != M_IDLE));
    endtask

    task automatic frames(int n);
        repeat (n) begin
            repeat (3) step();
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
        end
        step();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [9:0]  tp_cols [5] = '{10'd0, 10'd90, 10'd170, 10'd330, 10'd600};
    logic [23:0] tp_exp  [5] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h000000};

    initial begin
        rst = 1'b1; row = '0; col = '0; pix_valid = 1'b0; frame_start = 1'b0;
        act = '0; en = '0; req = '0; tp = 1'b0;
        for (int i = 0; i < N; i++) lc[i] = 24'h0;

        // Reset held for three clocks with idle inputs
        repeat (3) step();
        check("rst_color", 32'(output_color), 32'h0);
        check("rst_valid", 32'(output_valid), 32'h0);
        check("rst_shown", 32'(shown_screen), 32'h0);
        check("rst_busy",  32'(fade_busy), 32'h0);
        rst = 1'b0;

        // Priority merge
        pix_valid = 1'b1;
        lc[0] = 24'hFF0000; lc[2] = 24'h00FF00;
        act = 6'b000101; en = '1;
        step();
        step();
        check("prio_top", 32'(output_color), 32'h00FF00);
        check("prio_valid", 32'(output_valid), 32'h1);
        en[2] = 1'b0;
        step();
        step();
        check("prio_masked", 32'(output_color), 32'hFF0000);

        // Test pattern bars and lower half
        tp = 1'b1; row = 10'd10;
        for (int k = 0; k < 5; k++) begin
            col = tp_cols[k];
            step();
            step();
            check("tp_bar", 32'(output_color), 32'(tp_exp[k]));
        end
        row = 10'd300; col = 10'd0;
        step();
        step();
        check("tp_lower", 32'(output_color), 32'h0);
        tp = 1'b0;

        // Full fade 0 -> 2 over a white top layer
        lc[5] = 24'hFFFFFF; act = '1; en = '1; row = 10'd20; col = 10'd20;
        req = 3'd2;
        step();
        frames(4);
        check("fade_half", 32'(output_color), 32'h7F7F7F);
        check("fade_half_busy", 32'(fade_busy), 32'h1);
        frames(4);
        check("fade_black", 32'(output_color), 32'h0);
        check("fade_swap", 32'(shown_screen), 32'h2);
        frames(8);
        check("fade_white", 32'(output_color), 32'hFFFFFF);
        check("fade_done", 32'(fade_busy), 32'h0);

        // Retarget mid fade-out, reverse mid fade-in
        req = 3'd0;
        do_reset();
        req = 3'd2;
        step();
        frames(3);
        req = 3'd3;
        step();
        frames(5);
        check("retarget_shown", 32'(shown_screen), 32'h3);
        frames(3);
        check("fadein_l3", 32'(output_color), 32'h5F5F5F);
        req = 3'd1;
        step();
        step();
        check("reverse_busy", 32'(fade_busy), 32'h1);
        frames(1);
        check("reverse_l2", 32'(output_color), 32'h3F3F3F);
        frames(2);
        check("reverse_shown", 32'(shown_screen), 32'h1);

        // Reset in the middle of a fade-in
        req = 3'd0;
        do_reset();
        req = 3'd1;
        step();
        frames(8);
        frames(4);
        check("pre_rst_l4", 32'(output_color), 32'h7F7F7F);
        rst = 1'b1; req = 3'd0;
        step();
        check("midrst_shown", 32'(shown_screen), 32'h0);
        check("midrst_busy", 32'(fade_busy), 32'h0);
        check("midrst_color", 32'(output_color), 32'h0);
        check("midrst_valid", 32'(output_valid), 32'h0);
        rst = 1'b0;
        step();
        step();
        check("post_rst_full", 32'(output_color), 32'hFFFFFF);

        // Random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            row = 10'($urandom_range(0, 479));
            col = 10'($urandom_range(0, 639));
            pix_valid = 1'($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) lc[i] = 24'($urandom);
            act = N'($urandom);
            en  = N'($urandom);
            tp  = ($urandom_range(0, 7) == 0);
            frame_start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 149) == 0) req = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0; frame_start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
